// File: rtl/bit_serial_deserializer.sv
// Bit-serial receiver: collects LSB-first bits into WIDTH-bit words and presents them on a
// valid/ready output register, so the next word can shift in while the current one is held.
module bit_serial_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             RN,
  input  logic             SI,
  input  logic             SV,
  input  logic             SS,
  output logic [WIDTH-1:0] Q,
  output logic             QV,
  input  logic             QR,
  output logic             BUSY,
  output logic             OVF,
  output logic             TRUNC
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qv_q, qv_d;
  logic             ovf_q, ovf_d;
  logic             trunc_q, trunc_d;
  logic             word_done;
  logic [WIDTH-1:0] word;

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      q_q     <= '0;
      qv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
      ovf_q   <= ovf_d;
      trunc_q <= trunc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    q_d       = q_q;
    qv_d      = qv_q;
    ovf_d     = ovf_q;
    trunc_d   = trunc_q;
    word_done = 1'b0;
    // The last bit goes straight into the output word, never through the shift register.
    word      = {SI, shift_q[WIDTH-2:0]};

    case (state_q)
      IDLE: begin
        if (SV && SS) begin
          shift_d    = '0;
          shift_d[0] = SI;
          cnt_d      = CW'(1);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (SV) begin
          if (SS) begin
            trunc_d    = 1'b1;
            shift_d    = '0;
            shift_d[0] = SI;
            cnt_d      = CW'(1);
          end else if (cnt_q == LAST) begin
            word_done = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            shift_d[cnt_q] = SI;
            cnt_d          = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (qv_q && QR) begin
      qv_d = 1'b0;
    end
    // A held word consumed on the completion edge makes room for the new one without a bubble.
    if (word_done) begin
      if (!qv_q || QR) begin
        q_d  = word;
        qv_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  assign Q     = q_q;
  assign QV    = qv_q;
  assign BUSY  = (state_q == SHIFT);
  assign OVF   = ovf_q;
  assign TRUNC = trunc_q;

endmodule

// File: tb/tb_bit_serial_deserializer.sv
// Directed bench for bit_serial_deserializer: stimulus pushes expected words into a scoreboard
// queue, a monitor pops and compares on each output transfer; flags are checked inline.
module tb_bit_serial_deserializer;

  localparam int WIDTH = 8;

  logic             C;
  logic             RN;
  logic             SI;
  logic             SV;
  logic             SS;
  logic [WIDTH-1:0] Q;
  logic             QV;
  logic             QR;
  logic             BUSY;
  logic             OVF;
  logic             TRUNC;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] sb[$];

  bit_serial_deserializer #(.WIDTH(WIDTH)) dut (
    .C(C), .RN(RN), .SI(SI), .SV(SV), .SS(SS),
    .Q(Q), .QV(QV), .QR(QR), .BUSY(BUSY), .OVF(OVF), .TRUNC(TRUNC)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge whenever QV&QR is seen here.
  always @(negedge C) begin
    if (RN && QV && QR) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got 0x%0h expected no word at %0t", Q, $time);
      end else begin
        chk("sb_word", 32'(Q), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic drive_bit(input logic b, input logic s);
    SI = b;
    SS = s;
    SV = 1'b1;
    tick();
    SV = 1'b0;
    SS = 1'b0;
    SI = 1'bx;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input int gapmode);
    for (int i = 0; i < WIDTH; i++) begin
      drive_bit(w[i], i == 0);
      if (gapmode != 0 && i < WIDTH - 1) repeat ((i % 3) + 1) tick();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_q"}, 32'(Q), 32'h0);
    chk({tag, "_qv"}, 32'(QV), 32'h0);
    chk({tag, "_busy"}, 32'(BUSY), 32'h0);
    chk({tag, "_ovf"}, 32'(OVF), 32'h0);
    chk({tag, "_trunc"}, 32'(TRUNC), 32'h0);
  endtask

  task automatic do_reset();
    @(posedge C);
    #3 RN = 1'b0;
    #1 chk_reset_outputs("rst");
    @(posedge C);
    #3 RN = 1'b1;
    tick();
  endtask

  initial begin
    RN = 1'b0;
    SI = 1'b0;
    SV = 1'b0;
    SS = 1'b0;
    QR = 1'b0;
    #1 chk_reset_outputs("por");
    #12 RN = 1'b1;
    tick();

    // 1: 0xA5 at full rate, QR=1
    QR = 1'b1;
    sb.push_back(8'hA5);
    for (int i = 0; i < WIDTH; i++) begin
      logic [7:0] w;
      w = 8'hA5;
      drive_bit(w[i], i == 0);
      if (i < WIDTH - 1) chk("t1_busy", 32'(BUSY), 32'h1);
    end
    chk("t1_busy_end", 32'(BUSY), 32'h0);
    chk("t1_qv", 32'(QV), 32'h1);
    chk("t1_q", 32'(Q), 32'hA5);
    tick();
    chk("t1_qv_drop", 32'(QV), 32'h0);

    // 2: 0x3C with gaps between bits
    do_reset();
    QR = 1'b1;
    sb.push_back(8'h3C);
    send_word(8'h3C, 1);
    chk("t2_q", 32'(Q), 32'h3C);
    chk("t2_qv", 32'(QV), 32'h1);
    chk("t2_ovf", 32'(OVF), 32'h0);
    chk("t2_trunc", 32'(TRUNC), 32'h0);
    tick();

    // 3: QR=0, 0x11 then 0x22 back-to-back -> 0x22 dropped
    do_reset();
    QR = 1'b0;
    sb.push_back(8'h11);
    send_word(8'h11, 0);
    send_word(8'h22, 0);
    chk("t3_q", 32'(Q), 32'h11);
    chk("t3_qv", 32'(QV), 32'h1);
    chk("t3_ovf", 32'(OVF), 32'h1);
    QR = 1'b1;
    tick();
    QR = 1'b0;
    chk("t3_qv_drop", 32'(QV), 32'h0);
    chk("t3_q_hold", 32'(Q), 32'h11);

    // 4: QR raised exactly on the completion edge of 0x22
    do_reset();
    QR = 1'b0;
    sb.push_back(8'h11);
    send_word(8'h11, 0);
    sb.push_back(8'h22);
    for (int i = 0; i < WIDTH; i++) begin
      logic [7:0] w;
      w = 8'h22;
      if (i == WIDTH - 1) QR = 1'b1;
      drive_bit(w[i], i == 0);
    end
    chk("t4_q", 32'(Q), 32'h22);
    chk("t4_qv", 32'(QV), 32'h1);
    chk("t4_ovf", 32'(OVF), 32'h0);
    tick();
    chk("t4_qv_drop", 32'(QV), 32'h0);

    // 5: 4 bits then a new SS word 0xF0 -> truncation
    do_reset();
    QR = 1'b1;
    drive_bit(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0);
    chk("t5_busy", 32'(BUSY), 32'h1);
    chk("t5_trunc_pre", 32'(TRUNC), 32'h0);
    sb.push_back(8'hF0);
    send_word(8'hF0, 0);
    chk("t5_trunc", 32'(TRUNC), 32'h1);
    chk("t5_q", 32'(Q), 32'hF0);
    chk("t5_qv", 32'(QV), 32'h1);
    tick();

    // 6: async reset mid-word with a word held and flags set
    do_reset();
    QR = 1'b0;
    send_word(8'h5A, 0);
    send_word(8'h77, 0);
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b0);
    chk("t6_pre_qv", 32'(QV), 32'h1);
    chk("t6_pre_ovf", 32'(OVF), 32'h1);
    chk("t6_pre_trunc", 32'(TRUNC), 32'h1);
    chk("t6_pre_busy", 32'(BUSY), 32'h1);
    #3 RN = 1'b0;
    #1 chk_reset_outputs("t6_async");
    @(posedge C);
    #3 RN = 1'b1;
    tick();
    QR = 1'b1;
    sb.push_back(8'h81);
    send_word(8'h81, 0);
    chk("t6_q", 32'(Q), 32'h81);
    chk("t6_qv", 32'(QV), 32'h1);
    chk("t6_busy", 32'(BUSY), 32'h0);
    tick();
    QR = 1'b0;
    repeat (3) tick();

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
